// File: rtl/averager_channel_scheduler.sv
// averager_channel_scheduler
//   Shares one power-of-two signed averaging datapath among CHANNEL_COUNT
//   sample streams. A round-robin arbiter grants one channel and holds the
//   grant for a full burst of 2**POWER_OF_TWO_EXPONENT samples. The burst sum
//   is divided by an arithmetic shift that rounds toward zero, and the result
//   is presented with the number of the channel that produced it.
//
//   Optional build macro: AVERAGER_CHANNEL_SCHEDULER_TIMEOUT_EN
//     Adds a starvation timer and a `timeout` output port. When no sample
//     arrives for TIMEOUT_CYCLES during a burst, the partial burst is dropped,
//     `timeout` pulses for one cycle, and the scheduler returns to IDLE.
//
// Ports
//   clock           sole clock, rising edge
//   clear_n         asynchronous active-low reset
//   input_valid     per-channel sample valid
//   input_ready     per-channel sample ready (only the granted channel)
//   input_sample    packed samples, channel i at [i*WORD_WIDTH +: WORD_WIDTH]
//   output_valid    average available
//   output_ready    consumer accepts average
//   output_average  signed average
//   output_channel  channel that produced output_average
//   busy            high in any state except IDLE
//   input_overflow  sticky accumulator signed overflow (diagnostic)
//   timeout         one-cycle starvation pulse (optional build only)
module averager_channel_scheduler #(
    parameter int CHANNEL_COUNT         = 4,
    parameter int CHANNEL_ID_WIDTH      = 2,
    parameter int WORD_WIDTH            = 16,
    parameter int POWER_OF_TWO_EXPONENT = 3,
    parameter int TIMEOUT_CYCLES        = 255
) (
    input  logic                                clock,
    input  logic                                clear_n,
    input  logic [CHANNEL_COUNT-1:0]            input_valid,
    output logic [CHANNEL_COUNT-1:0]            input_ready,
    input  logic [CHANNEL_COUNT*WORD_WIDTH-1:0] input_sample,
    output logic                                output_valid,
    input  logic                                output_ready,
    output logic [WORD_WIDTH-1:0]               output_average,
    output logic [CHANNEL_ID_WIDTH-1:0]         output_channel,
    output logic                                busy,
    output logic                                input_overflow
`ifdef AVERAGER_CHANNEL_SCHEDULER_TIMEOUT_EN
    ,
    output logic                                timeout
`endif
);

    localparam int E     = POWER_OF_TWO_EXPONENT;
    localparam int W     = WORD_WIDTH;
    localparam int ACC_W = W + E;
    localparam int CIW   = CHANNEL_ID_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUMULATE,
        S_DIVIDE,
        S_OUTPUT
    } state_t;

    state_t                    state_q, state_d;
    logic [CIW-1:0]            grant_q, grant_d;
    logic [CIW-1:0]            last_grant_q, last_grant_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [E-1:0]              count_q, count_d;
    logic [W-1:0]              avg_q, avg_d;
    logic [CIW-1:0]            ochan_q, ochan_d;
    logic                      ovalid_q, ovalid_d;
    logic                      ovf_q, ovf_d;

    // Per-channel view of the packed sample bus.
    logic [CHANNEL_COUNT-1:0][W-1:0] samples;
    assign samples = input_sample;

    // Only the granted channel sees ready, and only while accumulating.
    genvar g;
    generate
        for (g = 0; g < CHANNEL_COUNT; g++) begin : g_ready
            assign input_ready[g] = (state_q == S_ACCUMULATE) && (grant_q == CIW'(g));
        end
    endgenerate

    // Round-robin search starting after last_grant: the lowest requester
    // above last_grant wins, otherwise the lowest requester at or below it.
    logic           hi_found, lo_found, found;
    logic [CIW-1:0] hi_sel, lo_sel, sel;
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int i = CHANNEL_COUNT - 1; i >= 0; i--) begin
            if (input_valid[i]) begin
                if (i > int'(last_grant_q)) begin
                    hi_found = 1'b1;
                    hi_sel   = CIW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_sel   = CIW'(i);
                end
            end
        end
        found = hi_found | lo_found;
        sel   = hi_found ? hi_sel : lo_sel;
    end

    // Accumulate datapath.
    logic                    accept;
    logic signed [ACC_W-1:0] sample_ext, sum_w;
    logic                    add_ovf;
    assign accept     = (state_q == S_ACCUMULATE) && input_valid[grant_q];
    assign sample_ext = {{E{samples[grant_q][W-1]}}, samples[grant_q]};
    assign sum_w      = acc_q + sample_ext;
    assign add_ovf    = (acc_q[ACC_W-1] == sample_ext[ACC_W-1]) &&
                        (sum_w[ACC_W-1] != acc_q[ACC_W-1]);

    // Divide: biasing negative sums by 2**E-1 turns the flooring shift
    // into truncation toward zero.
    logic signed [ACC_W-1:0] bias, adj;
    assign bias = acc_q[ACC_W-1] ? ACC_W'((1 << E) - 1) : '0;
    assign adj  = acc_q + bias;

`ifdef AVERAGER_CHANNEL_SCHEDULER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
    assign timeout = timeout_q;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        acc_d        = acc_q;
        count_d      = count_q;
        avg_d        = avg_q;
        ochan_d      = ochan_q;
        ovalid_d     = ovalid_q;
        ovf_d        = ovf_q;
`ifdef AVERAGER_CHANNEL_SCHEDULER_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    acc_d        = '0;
                    count_d      = '0;
                    state_d      = S_ACCUMULATE;
`ifdef AVERAGER_CHANNEL_SCHEDULER_TIMEOUT_EN
                    to_cnt_d     = '0;
`endif
                end
            end
            S_ACCUMULATE: begin
                if (accept) begin
                    acc_d   = sum_w;
                    count_d = count_q + 1'b1;
                    if (add_ovf) ovf_d = 1'b1;
                    // count wraps to zero on the last sample of the burst
                    if (count_q == {E{1'b1}}) state_d = S_DIVIDE;
`ifdef AVERAGER_CHANNEL_SCHEDULER_TIMEOUT_EN
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Starved: drop the partial burst, keep last_grant so the
                    // next search begins after the stalled channel.
                    timeout_d = 1'b1;
                    acc_d     = '0;
                    count_d   = '0;
                    ovf_d     = 1'b0;
                    to_cnt_d  = '0;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            S_DIVIDE: begin
                avg_d    = W'(adj >>> E);
                ochan_d  = grant_q;
                ovalid_d = 1'b1;
                state_d  = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (ovalid_q && output_ready) begin
                    ovalid_d = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= CIW'(CHANNEL_COUNT - 1);
            acc_q        <= '0;
            count_q      <= '0;
            avg_q        <= '0;
            ochan_q      <= '0;
            ovalid_q     <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef AVERAGER_CHANNEL_SCHEDULER_TIMEOUT_EN
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            avg_q        <= avg_d;
            ochan_q      <= ochan_d;
            ovalid_q     <= ovalid_d;
            ovf_q        <= ovf_d;
`ifdef AVERAGER_CHANNEL_SCHEDULER_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign output_valid   = ovalid_q;
    assign output_average = avg_q;
    assign output_channel = ochan_q;
    assign busy           = (state_q != S_IDLE);
    assign input_overflow = ovf_q;

endmodule

// File: tb/tb_averager_channel_scheduler.sv
// Scoreboard bench: directed bursts push expected {average, channel} into a
// queue; a monitor pops and compares on every output handshake.
module tb_averager_channel_scheduler;
    localparam int N   = 4;
    localparam int CIW = 2;
    localparam int W   = 16;
    localparam int E   = 3;

    logic                clock = 1'b0;
    logic                clear_n;
    logic [N-1:0]        input_valid;
    logic [N-1:0]        input_ready;
    logic [N*W-1:0]      input_sample;
    logic                output_valid;
    logic                output_ready;
    logic [W-1:0]        output_average;
    logic [CIW-1:0]      output_channel;
    logic                busy;
    logic                input_overflow;
`ifdef AVERAGER_CHANNEL_SCHEDULER_TIMEOUT_EN
    logic                timeout;
`endif

    always #5 clock = ~clock;

    averager_channel_scheduler #(
        .CHANNEL_COUNT(N), .CHANNEL_ID_WIDTH(CIW), .WORD_WIDTH(W),
        .POWER_OF_TWO_EXPONENT(E), .TIMEOUT_CYCLES(255)
    ) dut (
        .clock(clock), .clear_n(clear_n),
        .input_valid(input_valid), .input_ready(input_ready),
        .input_sample(input_sample),
        .output_valid(output_valid), .output_ready(output_ready),
        .output_average(output_average), .output_channel(output_channel),
        .busy(busy), .input_overflow(input_overflow)
`ifdef AVERAGER_CHANNEL_SCHEDULER_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    typedef struct {
        int avg;
        int ch;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: handshake seen at a negedge completes at the next posedge.
    always @(negedge clock) begin
        if (clear_n) begin
            chk("ready_onehot", int'($countones(input_ready) <= 1), 1);
            if (output_valid && output_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("avg", int'($signed(output_average)), e.avg);
                    chk("chan", int'(output_channel), e.ch);
                end
            end
        end
    end

    task automatic push(input int avg, input int ch);
        exp_t e;
        e.avg = avg;
        e.ch  = ch;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear_n     = 1'b0;
        input_valid = '0;
        exp_q.delete();
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    // Present one sample; returns at the negedge before the accepting edge.
    task automatic drive(input int ch, input int v, output int waited);
        @(negedge clock);
        input_valid[ch]         = 1'b1;
        input_sample[ch*W +: W] = W'(v);
        waited = 0;
        while (!input_ready[ch] && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 100) chk("drive_timeout", waited, 0);
    endtask

    task automatic send_burst(input int ch, input int vals[8], output int first_wait);
        int w;
        first_wait = 0;
        for (int k = 0; k < 8; k++) begin
            drive(ch, vals[k], w);
            if (k == 0) first_wait = w;
        end
        @(negedge clock);
        input_valid[ch] = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!output_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!output_valid) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int fw;
        int n;
        clear_n      = 1'b0;
        input_valid  = '0;
        input_sample = '0;
        output_ready = 1'b1;
        #12;
        // Reset state
        chk("rst_ready", int'(input_ready), 0);
        chk("rst_valid", int'(output_valid), 0);
        chk("rst_avg", int'(output_average), 0);
        chk("rst_chan", int'(output_channel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(input_overflow), 0);
        @(negedge clock);
        clear_n = 1'b1;

        // Channel 1, eight -3: one-cycle grant, two-cycle output latency
        push(-3, 1);
        send_burst(1, '{-3, -3, -3, -3, -3, -3, -3, -3}, fw);
        chk("grant_latency", fw, 1);
        chk("lat_cycle1_valid", int'(output_valid), 0);
        @(negedge clock);
        chk("lat_cycle2_valid", int'(output_valid), 1);
        wait_drain(50);

        // Round toward zero on channel 0
        push(0, 0);
        send_burst(0, '{-1, 0, 0, 0, 0, 0, 0, 0}, fw);
        wait_drain(50);
        push(-1, 0);
        send_burst(0, '{-9, 0, 0, 0, 0, 0, 0, 0}, fw);
        wait_drain(50);
        push(0, 0);
        send_burst(0, '{7, 0, 0, 0, 0, 0, 0, 0}, fw);
        wait_drain(50);
        push(32767, 0);
        send_burst(0, '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767}, fw);
        wait_valid();
        chk("max_ovf", int'(input_overflow), 0);
        wait_drain(50);

        // Output back-pressure: data held, no input accepted, then next grant
        output_ready = 1'b0;
        push(10, 2);
        send_burst(2, '{10, 10, 10, 10, 10, 10, 10, 10}, fw);
        wait_valid();
        input_sample = {16'sd20, 16'sd1000, 16'sd0, -16'sd50};
        input_valid  = 4'b1011;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("stall_valid", int'(output_valid), 1);
            chk("stall_avg", int'($signed(output_average)), 10);
            chk("stall_chan", int'(output_channel), 2);
            chk("stall_ready", int'(input_ready), 0);
        end
        @(posedge clock);
        #1 output_ready = 1'b1;
        n = 0;
        @(negedge clock);
        while (input_ready == '0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("next_grant_after_2", int'(input_ready), 4'b1000);
        wait_drain(10);

        // Round robin with all channels continuously valid
        do_reset();
        input_sample = {16'sd20, -16'sd7, 16'sd1000, -16'sd50};
        push(-50, 0);
        push(1000, 1);
        push(-7, 2);
        push(20, 3);
        push(-50, 0);
        @(negedge clock);
        input_valid = 4'b1111;
        wait_drain(300);
        input_valid = '0;

        // Reset mid-burst on channel 2 discards the partial sum
        do_reset();
        for (int k = 0; k < 5; k++) drive(2, 100, fw);
        @(negedge clock);
        chk("pre_clr_busy", int'(busy), 1);
        clear_n     = 1'b0;
        input_valid = '0;
        #1;
        chk("clr_ready", int'(input_ready), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_valid", int'(output_valid), 0);
        chk("clr_avg", int'(output_average), 0);
        chk("clr_chan", int'(output_channel), 0);
        chk("clr_ovf", int'(input_overflow), 0);
        @(negedge clock);
        clear_n = 1'b1;
        push(4, 2);
        send_burst(2, '{4, 4, 4, 4, 4, 4, 4, 4}, fw);
        chk("regrant_latency", fw, 1);
        wait_drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

endmodule
